ioctl_load_sequencer: RTL and testbench
=======================================

Name: ioctl_load_sequencer

Overview:
- Sequences the HPS ioctl download stream into the game core and owns core reset during and after loading.
- Routes each byte by index:
  - index 0: ROM bytes, passed through a small FIFO onto the core's ROM write port, which has a ready handshake.
  - index 1: title number.
  - index 254: DIP-switch bytes.
- Sits between hps_io and fpga_druaga. Replaces the ad-hoc tno/sw registers and the reset OR-ing in emu.

Parameters:
- FIFO_DEPTH, 4: ROM byte FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 16: cycles core_reset stays high after download drain or power-up; minimum 1.
- ADDR_W, 25: ioctl/ROM address width.

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ext_reset  in  1  synchronous core reset request (RESET | status[0] | buttons[1]), active high.
- dl_active  in  1  ioctl_download.
- dl_wr  in  1  ioctl_wr strobe, one cycle per byte.
- dl_index  in  8  ioctl_index.
- dl_addr  in  ADDR_W  ioctl_addr.
- dl_data  in  8  ioctl_dout.
- rom_wr  out  1  ROM write valid.
- rom_addr  out  ADDR_W  ROM write address.
- rom_data  out  8  ROM write data.
- rom_ready  in  1  core accepts the ROM write this cycle.
- tno  out  4  title number.
- dsw  out  24  {sw[2],sw[1],sw[0]}.
- core_reset  out  1  reset to game core, active high.
- overflow  out  1  sticky: an index-0 byte was dropped.
- busy  out  1  state != RUN.
- rom_sum  out  8  ROM checksum (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous) values:
  - state=HOLD, hold counter=HOLD_CYCLES-1.
  - core_reset=1, busy=1, rom_wr=0, rom_addr=0, rom_data=0.
  - tno=0, dsw=0, overflow=0, rom_sum=0, FIFO empty.
- Routing, evaluated each cycle with dl_wr=1:
  - index 0: push {addr,data} into the FIFO. If the FIFO is full and there is no pop the same cycle, drop the byte and set overflow. Push-on-full with a simultaneous pop is accepted.
  - index 1: tno <= dl_data[3:0], at any address; the last write wins.
  - index 254 with dl_addr < 8: sw[dl_addr[2:0]] <= dl_data. Only sw[0..2] reach dsw. Writes at dl_addr >= 8 are ignored.
  - Any other index: ignored.
- Routing is active in every state and is not gated by dl_active.
- ROM port:
  - rom_wr=1 whenever the FIFO is non-empty; rom_addr/rom_data present the FIFO head.
  - A pop occurs when rom_wr & rom_ready.
  - A byte pushed in cycle N first appears on rom_wr/rom_addr/rom_data in cycle N+1 (registered FIFO, empty-bypass not allowed).
  - The FIFO preserves order. rom_addr/rom_data hold their value while rom_wr=0.
- State machine (registered, clk_sys):
  - RUN: core_reset = ext_reset, busy=0. On dl_active=1 go to LOAD.
  - LOAD: core_reset=1. On dl_active=0 go to DRAIN.
  - DRAIN: core_reset=1. When the FIFO is empty, load the counter with HOLD_CYCLES-1 and go to HOLD. If dl_active returns to 1, go to LOAD.
  - HOLD: core_reset=1. Decrement the counter each cycle; at 0 go to RUN. If dl_active=1, go to LOAD.
- core_reset is registered and follows the state one cycle later. ext_reset in RUN reaches core_reset with 1-cycle latency. ext_reset is ignored in LOAD/DRAIN/HOLD.
- overflow clears on entry to LOAD.
- reset_n asserted mid-download: FIFO contents are discarded, and the state machine and all outputs return to their reset values.

Optional Feature:
- Macro ROM_CHECKSUM_EN.
- With the macro defined: rom_sum is an 8-bit wrapping sum of rom_data over every accepted transfer (rom_wr & rom_ready). It clears to 0 on entry to LOAD and holds otherwise.
- Without the macro: rom_sum is tied to 8'h00 and no adder is synthesised.

Decomposition:
- Package druaga_load_pkg holds:
  - enum load_state_t {RUN, LOAD, DRAIN, HOLD};
  - localparams IDX_ROM=8'd0, IDX_TNO=8'd1, IDX_DSW=8'd254, DSW_BYTES=8.
- One sub-module: load_fifo, a synchronous FIFO with parameters WIDTH=ADDR_W+8 and DEPTH=FIFO_DEPTH. It has push/pop/full/empty, pointers with an extra wrap bit, and asynchronous active-low reset.

Test Plan:
- Power-up: release reset_n. Require core_reset=1 for exactly 16 cycles after release, then 0 with busy=0, and tno=0, dsw=0.
- Download with rom_ready=1:
  - Stimulus: dl_active=1; index 0, bytes 0x11,0x22,0x33 at addresses 0,1,2; then dl_active=0.
  - Require rom_wr pulses in the same order with matching addresses, one cycle after each push, and core_reset=1 throughout.
  - Require core_reset to fall 16 cycles after the FIFO drains.
  - With ROM_CHECKSUM_EN, require rom_sum=0x66.
- Backpressure: hold rom_ready=0 and push 5 bytes with FIFO_DEPTH=4. Require the 5th to be dropped and overflow=1. Release rom_ready and require 4 bytes out in order. Require overflow to clear on the next dl_active rising edge.
- Config writes:
  - index 1, data 0x25: require tno=5.
  - index 254 at addresses 0/1/2/9 with data 0xAA/0xBB/0xCC/0xDD: require dsw=24'hCCBBAA, with address 9 ignored.
- Re-download during HOLD: raise dl_active at hold counter=8. Require an immediate return to LOAD, core_reset to stay 1 with no glitch, and a full 16-cycle hold after the next drain.
- ext_reset: pulse for 3 cycles in RUN and require core_reset high for those 3 cycles, delayed by 1. A pulse during LOAD must have no additional effect.

Source files
------------

// File: rtl/ioctl_load_sequencer_pkg.sv
// rtl/ioctl_load_sequencer_pkg.sv - shared states and ioctl index constants for the load sequencer
package druaga_load_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } load_state_t;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_TNO   = 8'd1;
  localparam logic [7:0] IDX_DSW   = 8'd254;
  localparam int         DSW_BYTES = 8;

endpackage

// File: rtl/ioctl_load_sequencer_fifo.sv
// rtl/ioctl_load_sequencer_fifo.sv - registered synchronous FIFO for ROM address/data pairs
module load_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             pop_ok;
  logic             push_ok;

  // Extra wrap bit distinguishes full from empty when the slot indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; never read while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ioctl_load_sequencer.sv
// rtl/ioctl_load_sequencer.sv - routes ioctl download bytes and owns core reset; ROM_CHECKSUM_EN adds rom_sum
module ioctl_load_sequencer
  import druaga_load_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ADDR_W      = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ext_reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_index,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic [3:0]        tno,
  output logic [23:0]       dsw,
  output logic              core_reset,
  output logic              overflow,
  output logic              busy,
  output logic [7:0]        rom_sum
);

  localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam int               FW        = ADDR_W + 8;

  load_state_t      state_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             core_reset_q;
  logic [3:0]       tno_q;
  logic [7:0]       sw_q [3];
  logic             overflow_q;
  logic [FW-1:0]    rom_hold_q;

  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic             rom_req;
  logic             rom_drop;
  logic             enter_load;

  assign rom_req    = dl_wr && (dl_index == IDX_ROM);
  assign fifo_pop   = !fifo_empty && rom_ready;
  assign fifo_push  = rom_req && (!fifo_full || fifo_pop);
  assign rom_drop   = rom_req && fifo_full && !fifo_pop;
  assign enter_load = dl_active && (state_q != LOAD);

  load_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({dl_addr, dl_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ROM port shows the FIFO head; when idle it keeps the last transferred pair.
  assign rom_wr                = !fifo_empty;
  assign {rom_addr, rom_data}  = fifo_empty ? rom_hold_q : fifo_rdata;

  // Remember the most recent accepted transfer so the idle port does not wander.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      rom_hold_q <= '0;
    else if (fifo_pop) rom_hold_q <= fifo_rdata;
  end

  // Load sequencing: core_reset lags the state by one cycle; ext_reset only matters in RUN.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HOLD;
      hold_cnt_q   <= HOLD_INIT;
      core_reset_q <= 1'b1;
    end else begin
      core_reset_q <= (state_q == RUN) ? ext_reset : 1'b1;
      case (state_q)
        RUN:   if (dl_active) state_q <= LOAD;
        LOAD:  if (!dl_active) state_q <= DRAIN;
        DRAIN: begin
          if (dl_active) begin
            state_q <= LOAD;
          end else if (fifo_empty) begin
            hold_cnt_q <= HOLD_INIT;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (dl_active)              state_q    <= LOAD;
          else if (hold_cnt_q == '0)  state_q    <= RUN;
          else                        hold_cnt_q <= hold_cnt_q - 1'b1;
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  // Config bytes and the sticky drop flag; a drop in the LOAD-entry cycle still sets it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tno_q      <= '0;
      sw_q       <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      if (dl_wr && dl_index == IDX_TNO) tno_q <= dl_data[3:0];
      if (dl_wr && dl_index == IDX_DSW && dl_addr < ADDR_W'(DSW_BYTES)) begin
        for (int i = 0; i < 3; i++) begin
          if (dl_addr[2:0] == 3'(i)) sw_q[i] <= dl_data;
        end
      end
      if (rom_drop)        overflow_q <= 1'b1;
      else if (enter_load) overflow_q <= 1'b0;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [7:0] rom_sum_q;

  // Running 8-bit sum of accepted ROM bytes, restarted at each new download.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        rom_sum_q <= '0;
    else if (enter_load) rom_sum_q <= '0;
    else if (fifo_pop)   rom_sum_q <= rom_sum_q + fifo_rdata[7:0];
  end

  assign rom_sum = rom_sum_q;
`else
  assign rom_sum = 8'h00;
`endif

  assign tno        = tno_q;
  assign dsw        = {sw_q[2], sw_q[1], sw_q[0]};
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != RUN);

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// tb/tb_ioctl_load_sequencer.sv - scoreboard bench for ioctl_load_sequencer
module tb_ioctl_load_sequencer;

  localparam int AW    = 25;
  localparam int DEPTH = 4;
  localparam int HOLDC = 16;
  localparam int S_RUN = 0, S_LOAD = 1, S_DRAIN = 2, S_HOLD = 3;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ext_reset = 1'b0;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [7:0]    dl_index = '0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          rom_ready = 1'b0;
  logic          rom_wr;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [3:0]    tno;
  logic [23:0]   dsw;
  logic          core_reset;
  logic          overflow;
  logic          busy;
  logic [7:0]    rom_sum;

  always #5 clk_sys = ~clk_sys;

  ioctl_load_sequencer dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ext_reset  (ext_reset),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_index   (dl_index),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .rom_wr     (rom_wr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ready  (rom_ready),
    .tno        (tno),
    .dsw        (dsw),
    .core_reset (core_reset),
    .overflow   (overflow),
    .busy       (busy),
    .rom_sum    (rom_sum)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+7:0] exp_q [$];

  int         m_state;
  int         m_hold;
  int         m_occ;
  bit         m_cr;
  bit         m_ov;
  logic [3:0] m_tno;
  logic [7:0] m_sw [3];
  logic [7:0] m_sum;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_HOLD;
    m_hold  = HOLDC - 1;
    m_occ   = 0;
    m_cr    = 1'b1;
    m_ov    = 1'b0;
    m_tno   = '0;
    m_sum   = '0;
    for (int i = 0; i < 3; i++) m_sw[i] = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the reference model, then check after the edge.
  task automatic step(input bit act, input bit wr, input bit ext, input bit rdy,
                      input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
    bit pop, req, acc, drop, enter;
    dl_active = act; dl_wr = wr; ext_reset = ext; rom_ready = rdy;
    dl_index = idx; dl_addr = a; dl_data = d;

    pop   = (m_occ > 0) && rdy;
    req   = wr && (idx == 8'd0);
    acc   = req && ((m_occ < DEPTH) || pop);
    drop  = req && !acc;
    enter = act && (m_state != S_LOAD);

    if (enter) m_sum = '0;
    else if (pop && exp_q.size() > 0) m_sum = m_sum + exp_q[0][7:0];
    m_cr = (m_state == S_RUN) ? ext : 1'b1;
    case (m_state)
      S_RUN:   if (act) m_state = S_LOAD;
      S_LOAD:  if (!act) m_state = S_DRAIN;
      S_DRAIN: begin
        if (act) m_state = S_LOAD;
        else if (m_occ == 0) begin m_hold = HOLDC - 1; m_state = S_HOLD; end
      end
      default: begin
        if (act) m_state = S_LOAD;
        else if (m_hold == 0) m_state = S_RUN;
        else m_hold--;
      end
    endcase
    m_occ = m_occ - int'(pop) + int'(acc);
    if (acc) exp_q.push_back({a, d});
    if (drop) m_ov = 1'b1;
    else if (enter) m_ov = 1'b0;
    if (wr && idx == 8'd1) m_tno = d[3:0];
    if (wr && idx == 8'd254 && a < 3) m_sw[a] = d;

    @(posedge clk_sys); #1;
    chk("core_reset", core_reset, m_cr);
    chk("busy", busy, m_state != S_RUN);
    chk("rom_wr", rom_wr, m_occ != 0);
    chk("overflow", overflow, m_ov);
    chk("tno", tno, m_tno);
    chk("dsw", dsw, {m_sw[2], m_sw[1], m_sw[0]});
`ifdef ROM_CHECKSUM_EN
    chk("rom_sum", rom_sum, m_sum);
`else
    chk("rom_sum", rom_sum, 8'h00);
`endif
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 8'd0, '0, 8'd0);
  endtask

  task automatic run_until_run(input string nm);
    int n;
    n = 0;
    while (m_state != S_RUN && n < 60) begin idle(1'b1); n++; end
    idle(1'b1);
    chk(nm, m_state == S_RUN, 1'b1);
  endtask

  // Monitor: every accepted ROM transfer must match the oldest expected entry.
  initial begin : monitor
    logic [AW+7:0] last;
    logic [AW+7:0] got;
    last = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        last = '0;
      end else if (rom_wr) begin
        if (rom_ready) begin
          got = {rom_addr, rom_data};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rom_unexpected: got %h with no pending entry", got);
          end else begin
            chk("rom_xfer", got, exp_q.pop_front());
            last = got;
          end
        end
      end else begin
        chk("rom_idle_hold", {rom_addr, rom_data}, last);
      end
    end
  end

  initial begin : main
    int n;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_busy", busy, 1'b1);
    chk("rst_rom_wr", rom_wr, 1'b0);
    chk("rst_rom_addr", {rom_addr, rom_data}, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_tno_dsw", {tno, dsw}, '0);
    chk("rst_rom_sum", rom_sum, 8'h00);
    reset_n = 1'b1;

    // Power-up hold length
    n = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1'b1);
      if (core_reset) n++;
      else break;
    end
    chk("powerup_hold_len", n, HOLDC);

    // Simple download with rom_ready=1
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 25'd0, 8'h11);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 25'd1, 8'h22);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 25'd2, 8'h33);
    run_until_run("dl_returns_run");
`ifdef ROM_CHECKSUM_EN
    chk("rom_sum_66", rom_sum, 8'h66);
`endif

    // Backpressure and overflow
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0, 8'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, AW'(16 + i), 8'(8'h40 + i));
    chk("overflow_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("bp_queue_drained", exp_q.size(), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, 8'd0);
    chk("overflow_cleared", overflow, 1'b0);
    run_until_run("bp_returns_run");

    // Config writes
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 25'd3, 8'h25);
    chk("tno_5", tno, 4'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd254, 25'd0, 8'hAA);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd254, 25'd1, 8'hBB);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd254, 25'd2, 8'hCC);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd254, 25'd9, 8'hDD);
    chk("dsw_ccbbaa", dsw, 24'hCCBBAA);

    // Re-download while holding
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 25'd5, 8'h5A);
    n = 0;
    while (!(m_state == S_HOLD && m_hold == 8) && n < 40) begin idle(1'b1); n++; end
    chk("reached_hold8", m_state == S_HOLD && m_hold == 8, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, 8'd0);
    chk("redl_core_reset", core_reset, 1'b1);
    run_until_run("redl_returns_run");

    // ext_reset in RUN, then during LOAD
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, '0, 8'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, '0, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, '0, 8'd0);
    run_until_run("ext_returns_run");

    // Reset mid-download
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 25'd7, 8'h77);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 25'd0, 8'h09);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rom_wr", rom_wr, 1'b0);
    chk("midrst_core_reset", core_reset, 1'b1);
    chk("midrst_tno", tno, 4'd0);
    @(posedge clk_sys); #1;
    dl_active = 1'b0; dl_wr = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    run_until_run("midrst_returns_run");

    // Randomised traffic
    begin
      bit act;
      logic [7:0] idx;
      act = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) act = !act;
        case ($urandom_range(0, 3))
          0, 1:    idx = 8'd0;
          2:       idx = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
          default: idx = 8'd7;
        endcase
        step(act, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 6, idx, AW'($urandom_range(0, 11)), 8'($urandom));
      end
    end
    run_until_run("rand_returns_run");
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
